camera_frame_tx: RTL and testbench
==================================

# camera_frame_tx

Reads a stored frame back from the DMA MM2S AXI-Stream channel and replays it as a Camera Link-style parallel pixel stream, with FVAL/LVAL/DVAL framing and programmable line and frame blanking. It is the playback counterpart of the capture path that writes frames to DMA S2MM. Its outputs drive the loopback/emulation path and the downstream pixel consumers. It supports both camera formats: hawk (24-bit pixel) and owl (48-bit pixel).

## Interface
Parameters:
- LINE_GAP, 16: LVAL-low blanking cycles between lines (legal range ≥1).
- FRAME_GAP, 64: blanking cycles after the last line, before the block returns to idle (legal range ≥1).

Ports:
- sys_clk  in  1  the only clock.
- sys_rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle pulse that starts one frame; sampled only in IDLE.
- cameraSel  in  1  0 = hawk (pixel = tdata[23:0]); 1 = owl (pixel = tdata[47:0]). Latched at start.
- testMode  in  1  selects the internal pattern source (see Configuration). Latched at start.
- image_width  in  16  pixels per line, i.e. AXIS beats per line. Latched at start.
- image_height  in  16  lines per frame. Latched at start.
- M_AXIS_MM2S_0_tdata  in  64  stream data; one pixel per beat.
- M_AXIS_MM2S_0_tkeep  in  8  ignored.
- M_AXIS_MM2S_0_tlast  in  1  end-of-frame marker.
- M_AXIS_MM2S_0_tvalid  in  1  upstream beat valid.
- M_AXIS_MM2S_0_tready  out  1  ready toward the DMA.
- fval, lval, dval  out  1 each  frame, line and data valid.
- pixel  out  48  pixel data; bits [47:24] are zero in hawk mode.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse on leaving FGAP.
- err_short  out  1  sticky flag: tlast arrived before the final beat of the frame.
- err_long  out  1  sticky flag: no tlast on the final beat of the frame.

## Operation
- States:
  - IDLE → FSTART: on start, only if width ≠ 0 and height ≠ 0. Otherwise start is ignored.
  - FSTART → LINE: after 1 cycle.
  - LINE → LGAP: when the beat at col == width-1 is accepted and row < height-1.
  - LINE → FGAP: on that same beat when row == height-1 and tlast = 1.
  - LINE → DRAIN: on that same beat when row == height-1 and tlast = 0. This sets err_long.
  - LINE → FGAP (abort): on any earlier beat that carries tlast = 1. This sets err_short.
  - LGAP → LINE: after LINE_GAP cycles; row increments and col clears.
  - DRAIN → FGAP: when a beat with tlast = 1 is accepted. Beats consumed in DRAIN are discarded (dval stays 0).
  - FGAP → IDLE: after FRAME_GAP cycles; frame_done pulses.
- tready = (state == LINE) or (state == DRAIN). A beat is accepted when tvalid and tready are both 1.
- col and row are 16-bit counters. Width and height comparisons are unsigned. Counters never wrap within a legal frame.
- start asserted while busy is ignored.
- err_short and err_long clear only on sys_rst or on an accepted start.
- Stalls (tvalid = 0 in LINE): lval stays high, dval = 0, pixel holds its last value.

## Timing
- Reset values: state IDLE; fval, lval, dval, tready, busy, frame_done, err_short and err_long are 0; pixel is 0.
- All outputs except tready are registered. tready is combinational from the state only, never from tvalid.
- fval rises 1 cycle after start. It is high while state ∈ {FSTART, LINE, LGAP, DRAIN}, delayed by one register.
- lval is the registered value of (state == LINE). It therefore rises 1 cycle after fval.
- dval and pixel appear 1 cycle after beat acceptance: latency 1.
- The last dval of a line coincides with the last lval-high cycle.
- Blanking: LVAL is low for exactly LINE_GAP cycles between lines. Between the last dval and the fall of fval there is 1 cycle. frame_done comes FRAME_GAP cycles after FGAP entry.
- On the abort path, fval and lval both fall on the cycle after the tlast beat. The aborting beat is still output with dval = 1.
- A sys_rst mid-frame returns all outputs to their reset values on the next edge. Outstanding upstream beats are not drained; software resets the DMA.

## Configuration
- CAMERA_TX_PATTERN_EN defined:
  - With testMode latched at 1, tready is held at 0 and the stream is ignored.
  - Each pixel is {8'h00, row[15:0], col[15:0]}, masked to 24 bits in hawk mode. It is emitted every cycle in LINE.
  - The frame always terminates via LINE → FGAP. err flags are never set.
- CAMERA_TX_PATTERN_EN undefined: the testMode port is present but ignored, and the pattern logic is absent.

## Structure
- camera_pkg holds:
  - typedef enum tx_state_t {IDLE, FSTART, LINE, LGAP, DRAIN, FGAP};
  - constants HAWK_PIX_W = 24 and OWL_PIX_W = 48.
- Sub-module camera_gap_timer: loadable down-counter shared by LGAP and FGAP. Inputs are load, load value and enable; output is done.

## Test plan
- Hawk frame, 4×2, LINE_GAP = 2, FRAME_GAP = 3, tvalid always 1, tlast on the 8th beat → 8 dval pulses with pixel = tdata[23:0] and 2 lval windows 4 cycles wide, separated by exactly 2 low cycles; frame_done 3 cycles after FGAP entry; no error flags.
- Owl frame, 3×3, tvalid toggling 1/0 → 9 dval pulses, lval continuously high across stalls within each line, pixel[47:24] carries tdata[47:24].
- tlast on beat 5 of a 4×2 frame → fval/lval fall the next cycle, err_short = 1, FGAP runs, frame_done pulses; err_short clears on the next start.
- No tlast on beat 8 of a 4×2 frame, tlast on beat 10 → beats 9–10 consumed with dval = 0, err_long = 1, frame_done after FRAME_GAP.
- sys_rst asserted mid-line 1, and start with width = 0 → all outputs 0 the cycle after reset; start with width = 0 leaves busy = 0.
- CAMERA_TX_PATTERN_EN with testMode = 1, 2×2 owl → tready stays 0, pixels 0x0000_0000, 0x0000_0001, 0x0001_0000, 0x0001_0001.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera frame replay path.
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FSTART,
    LINE,
    LGAP,
    DRAIN,
    FGAP
  } tx_state_t;

  localparam int unsigned HAWK_PIX_W = 24;
  localparam int unsigned OWL_PIX_W  = 48;

endpackage

// File: rtl/camera_gap_timer.sv
// Loadable down-counter used to time both line and frame blanking.
module camera_gap_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            en,
  output logic            done
);

  logic [CntW-1:0] cnt_q;

  // Load has priority; otherwise count down while enabled and stop at zero.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/camera_frame_tx.sv
// Replays a stored frame from the MM2S stream as an FVAL/LVAL/DVAL pixel bus.
// Optional internal test pattern source enabled by defining CAMERA_TX_PATTERN_EN.
module camera_frame_tx
  import camera_pkg::*;
#(
  parameter int unsigned LINE_GAP  = 16,
  parameter int unsigned FRAME_GAP = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        cameraSel,
  input  logic        testMode,
  input  logic [15:0] image_width,
  input  logic [15:0] image_height,
  input  logic [63:0] M_AXIS_MM2S_0_tdata,
  input  logic [7:0]  M_AXIS_MM2S_0_tkeep,
  input  logic        M_AXIS_MM2S_0_tlast,
  input  logic        M_AXIS_MM2S_0_tvalid,
  output logic        M_AXIS_MM2S_0_tready,
  output logic        fval,
  output logic        lval,
  output logic        dval,
  output logic [47:0] pixel,
  output logic        busy,
  output logic        frame_done,
  output logic        err_short,
  output logic        err_long
);

  // Timer holds N-1 so that the gap state lasts exactly N cycles.
  localparam logic [15:0] LineGapLd  = 16'(LINE_GAP - 1);
  localparam logic [15:0] FrameGapLd = 16'(FRAME_GAP - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] col_q, row_q, width_q, height_q;
  logic        cam_sel_q;
  logic        fval_q, lval_q, dval_q, busy_q, done_q, err_s_q, err_l_q;
  logic [47:0] pixel_q;

  logic        pat_active, start_ok, beat, take_line, last_col, last_row;
  logic        err_s_set, err_l_set;
  logic        gap_load, gap_en, gap_done;
  logic [15:0] gap_val;
  logic [OWL_PIX_W-1:0] pix_src, pix_out;
  logic        unused_in;

`ifdef CAMERA_TX_PATTERN_EN
  logic test_mode_q;

  // Pattern mode latched at start; it replaces the stream entirely.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      test_mode_q <= 1'b0;
    end else if (start_ok) begin
      test_mode_q <= testMode;
    end
  end

  assign pat_active = test_mode_q;
  assign pix_src    = pat_active ? {8'h00, row_q, col_q} : M_AXIS_MM2S_0_tdata[47:0];
  assign unused_in  = ^{M_AXIS_MM2S_0_tkeep, M_AXIS_MM2S_0_tdata[63:48]};
`else
  assign pat_active = 1'b0;
  assign pix_src    = M_AXIS_MM2S_0_tdata[47:0];
  assign unused_in  = ^{M_AXIS_MM2S_0_tkeep, M_AXIS_MM2S_0_tdata[63:48], testMode};
`endif

  assign pix_out = cam_sel_q ? pix_src
                             : {{(OWL_PIX_W - HAWK_PIX_W){1'b0}}, pix_src[HAWK_PIX_W-1:0]};

  assign M_AXIS_MM2S_0_tready = !pat_active && ((state_q == LINE) || (state_q == DRAIN));
  assign beat      = M_AXIS_MM2S_0_tvalid && M_AXIS_MM2S_0_tready;
  assign take_line = (state_q == LINE) && (pat_active || beat);
  assign last_col  = (col_q == width_q - 16'd1);
  assign last_row  = (row_q == height_q - 16'd1);
  assign start_ok  = (state_q == IDLE) && start && (image_width != 16'd0)
                     && (image_height != 16'd0);

  // Next-state decode; an early tlast aborts the frame ahead of line-end handling.
  always_comb begin
    state_d   = state_q;
    err_s_set = 1'b0;
    err_l_set = 1'b0;
    unique case (state_q)
      IDLE:   if (start_ok) state_d = FSTART;
      FSTART: state_d = LINE;
      LINE: begin
        if (take_line) begin
          if (last_col && last_row) begin
            if (pat_active || M_AXIS_MM2S_0_tlast) begin
              state_d = FGAP;
            end else begin
              state_d   = DRAIN;
              err_l_set = 1'b1;
            end
          end else if (!pat_active && M_AXIS_MM2S_0_tlast) begin
            state_d   = FGAP;
            err_s_set = 1'b1;
          end else if (last_col) begin
            state_d = LGAP;
          end
        end
      end
      LGAP:   if (gap_done) state_d = LINE;
      DRAIN:  if (beat && M_AXIS_MM2S_0_tlast) state_d = FGAP;
      FGAP:   if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gap_load = (state_d != state_q) && ((state_d == LGAP) || (state_d == FGAP));
  assign gap_val  = (state_d == LGAP) ? LineGapLd : FrameGapLd;
  assign gap_en   = (state_q == LGAP) || (state_q == FGAP);

  camera_gap_timer #(
    .CntW(16)
  ) u_gap_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .load    (gap_load),
    .load_val(gap_val),
    .en      (gap_en),
    .done    (gap_done)
  );

  // State, frame geometry latch and pixel position counters.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      cam_sel_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        width_q   <= image_width;
        height_q  <= image_height;
        cam_sel_q <= cameraSel;
        col_q     <= '0;
        row_q     <= '0;
      end else if ((state_q == LGAP) && gap_done) begin
        row_q <= row_q + 16'd1;
        col_q <= '0;
      end else if (take_line && !last_col) begin
        col_q <= col_q + 16'd1;
      end
    end
  end

  // Registered outputs: framing lags state by one cycle, pixel lags its beat by one.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      dval_q  <= 1'b0;
      pixel_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_s_q <= 1'b0;
      err_l_q <= 1'b0;
    end else begin
      fval_q <= state_q inside {FSTART, LINE, LGAP, DRAIN};
      lval_q <= (state_q == LINE);
      dval_q <= take_line;
      if (take_line) pixel_q <= pix_out;
      busy_q <= (state_d != IDLE);
      done_q <= (state_q == FGAP) && gap_done;
      if (start_ok) begin
        err_s_q <= 1'b0;
        err_l_q <= 1'b0;
      end else begin
        if (err_s_set) err_s_q <= 1'b1;
        if (err_l_set) err_l_q <= 1'b1;
      end
    end
  end

  assign fval       = fval_q;
  assign lval       = lval_q;
  assign dval       = dval_q;
  assign pixel      = pixel_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err_short  = err_s_q;
  assign err_long   = err_l_q;

endmodule

// File: tb/tb_camera_frame_tx.sv
// Directed bench for camera_frame_tx with a pixel scoreboard and framing monitor.
module tb_camera_frame_tx;

  localparam int unsigned LG = 2;
  localparam int unsigned FG = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0, cameraSel = 1'b0, testMode = 1'b0;
  logic [15:0] image_width = '0, image_height = '0;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = 8'hff;
  logic        tlast = 1'b0, tvalid = 1'b0;
  logic        tready, fval, lval, dval, busy, frame_done, err_short, err_long;
  logic [47:0] pixel;

  camera_frame_tx #(
    .LINE_GAP (LG),
    .FRAME_GAP(FG)
  ) dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .start               (start),
    .cameraSel           (cameraSel),
    .testMode            (testMode),
    .image_width         (image_width),
    .image_height        (image_height),
    .M_AXIS_MM2S_0_tdata (tdata),
    .M_AXIS_MM2S_0_tkeep (tkeep),
    .M_AXIS_MM2S_0_tlast (tlast),
    .M_AXIS_MM2S_0_tvalid(tvalid),
    .M_AXIS_MM2S_0_tready(tready),
    .fval                (fval),
    .lval                (lval),
    .dval                (dval),
    .pixel               (pixel),
    .busy                (busy),
    .frame_done          (frame_done),
    .err_short           (err_short),
    .err_long            (err_long)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass = 0, n_chk = 0, cyc = 0;
  logic [47:0] exp_q[$];
  logic [47:0] exp_pix;
  int lval_runs[$], lval_gaps[$];
  int dval_cnt, run_len, low_len, last_fval_cyc, last_lval_cyc, acc_cyc, done_cyc;
  bit seen_line, lval_prev;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: pops scoreboard on dval, measures lval window widths and gaps.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (dval) begin
        dval_cnt++;
        if (exp_q.size() == 0) chk("dval_unexpected", 1, 0);
        else begin
          exp_pix = exp_q.pop_front();
          chk("pixel", {16'h0, pixel}, {16'h0, exp_pix});
        end
        if (!lval) chk("dval_outside_lval", 0, 1);
      end
      if (fval) last_fval_cyc = cyc;
      if (lval) last_lval_cyc = cyc;
      if (lval) begin
        if (!lval_prev && seen_line) lval_gaps.push_back(low_len);
        run_len++;
        low_len   = 0;
        seen_line = 1'b1;
      end else begin
        if (lval_prev) begin
          lval_runs.push_back(run_len);
          run_len = 0;
        end
        if (seen_line) low_len++;
      end
      lval_prev = lval;
    end
  end

  task automatic clear_stats();
    exp_q.delete();
    lval_runs.delete();
    lval_gaps.delete();
    dval_cnt  = 0;
    run_len   = 0;
    low_len   = 0;
    seen_line = 1'b0;
    lval_prev = 1'b0;
  endtask

  task automatic start_frame(input bit owl, input int w, input int h, input bit tm);
    cameraSel    = owl;
    image_width  = 16'(w);
    image_height = 16'(h);
    testMode     = tm;
    start        = 1'b1;
    @(negedge sys_clk);
    start        = 1'b0;
  endtask

  // Present one beat, wait (bounded) for tready, optionally expect it on the pixel bus.
  task automatic send(input logic [63:0] d, input bit last, input bit out, input bit owl);
    int n;
    n      = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    while (!tready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    if (!tready) chk("tready_timeout", 0, 1);
    if (out) exp_q.push_back(owl ? d[47:0] : {24'h0, d[23:0]});
    @(negedge sys_clk);
    acc_cyc = cyc;
    tvalid  = 1'b0;
    tlast   = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge sys_clk);
      if (frame_done) begin
        done_cyc = cyc;
        seen     = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", seen, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic chk_list(input string tag, input int q[$], input int exp_n, input int exp_v);
    chk({tag, "_count"}, q.size(), exp_n);
    for (int i = 0; i < q.size(); i++) chk(tag, q[i], exp_v);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_fval"}, fval, 0);
    chk({tag, "_lval"}, lval, 0);
    chk({tag, "_dval"}, dval, 0);
    chk({tag, "_pixel"}, pixel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_short"}, err_short, 0);
    chk({tag, "_err_long"}, err_long, 0);
    chk({tag, "_tready"}, tready, 0);
  endtask

  initial begin
    int tr_high;
    clear_stats();
    repeat (3) @(negedge sys_clk);
    chk_idle_outputs("reset");
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Hawk 4x2, back-to-back beats.
    clear_stats();
    start_frame(0, 4, 2, 0);
    chk("t1_busy_after_start", busy, 1);
    chk("t1_fval_lag", fval, 0);
    chk("t1_tready_fstart", tready, 0);
    for (int i = 0; i < 8; i++) send({$urandom, $urandom}, i == 7, 1, 0);
    wait_done();
    chk("t1_dval_cnt", dval_cnt, 8);
    chk_list("t1_lval_run", lval_runs, 2, 4);
    chk_list("t1_lval_gap", lval_gaps, 1, LG);
    chk("t1_done_latency", done_cyc - acc_cyc, FG);
    chk("t1_fval_fall", last_fval_cyc, acc_cyc);
    chk("t1_err_short", err_short, 0);
    chk("t1_err_long", err_long, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // Owl 3x3, tvalid toggling.
    clear_stats();
    start_frame(1, 3, 3, 0);
    for (int i = 0; i < 9; i++) begin
      send({$urandom, $urandom}, i == 8, 1, 1);
      if (i != 8) @(negedge sys_clk);
    end
    wait_done();
    chk("t2_dval_cnt", dval_cnt, 9);
    chk_list("t2_lval_run", lval_runs, 3, 5);
    chk_list("t2_lval_gap", lval_gaps, 2, LG);
    chk("t2_err_short", err_short, 0);
    chk("t2_err_long", err_long, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Early tlast on beat 5 of 4x2.
    clear_stats();
    start_frame(0, 4, 2, 0);
    for (int i = 0; i < 5; i++) send({$urandom, $urandom}, i == 4, 1, 0);
    wait_done();
    chk("t3_dval_cnt", dval_cnt, 5);
    chk("t3_fval_fall", last_fval_cyc, acc_cyc);
    chk("t3_lval_fall", last_lval_cyc, acc_cyc);
    chk("t3_done_latency", done_cyc - acc_cyc, FG);
    chk("t3_err_short", err_short, 1);
    chk("t3_err_long", err_long, 0);
    clear_stats();
    start_frame(0, 4, 2, 0);
    chk("t3_err_short_cleared", err_short, 0);
    for (int i = 0; i < 8; i++) send({$urandom, $urandom}, i == 7, 1, 0);
    wait_done();
    chk("t3b_dval_cnt", dval_cnt, 8);
    chk("t3b_err_short", err_short, 0);

    // Missing tlast on beat 8; tlast on beat 10, beats 9-10 discarded.
    clear_stats();
    start_frame(0, 4, 2, 0);
    for (int i = 0; i < 10; i++) send({$urandom, $urandom}, i == 9, i < 8, 0);
    wait_done();
    chk("t4_dval_cnt", dval_cnt, 8);
    chk("t4_done_latency", done_cyc - acc_cyc, FG);
    chk("t4_err_long", err_long, 1);
    chk("t4_err_short", err_short, 0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // Reset mid-line, then a zero-width start.
    clear_stats();
    start_frame(0, 4, 2, 0);
    send({$urandom, $urandom}, 0, 1, 0);
    send({$urandom, $urandom}, 0, 1, 0);
    chk("t5_busy_mid", busy, 1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_idle_outputs("t5_rst");
    sys_rst = 1'b0;
    clear_stats();
    @(negedge sys_clk);
    start_frame(0, 0, 2, 0);
    chk("t5_w0_busy", busy, 0);
    @(negedge sys_clk);
    chk("t5_w0_busy_later", busy, 0);
    chk("t5_w0_fval", fval, 0);

`ifdef CAMERA_TX_PATTERN_EN
    // Internal pattern, owl 2x2, stream held valid but must be ignored.
    clear_stats();
    exp_q.push_back(48'h0000_0000_0000);
    exp_q.push_back(48'h0000_0000_0001);
    exp_q.push_back(48'h0000_0001_0000);
    exp_q.push_back(48'h0000_0001_0001);
    tvalid  = 1'b1;
    tr_high = 0;
    start_frame(1, 2, 2, 1);
    for (int n = 0; n < 200 && !frame_done; n++) begin
      if (tready) tr_high++;
      @(negedge sys_clk);
    end
    tvalid = 1'b0;
    chk("t6_frame_done", frame_done, 1);
    chk("t6_tready_high", tr_high, 0);
    chk("t6_dval_cnt", dval_cnt, 4);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_err_short", err_short, 0);
    chk("t6_err_long", err_long, 0);
`else
    tr_high = 0;
`endif

    repeat (2) @(negedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
